// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key decoder: FSM state encoding,
// prefix bytes, shift key codes and the ignored control-byte list.
package ps2_pkg;

  // FSM states (legacy-compatible constant encoding)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Shift key codes
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Keyboard/controller status bytes that never form a key event on their own
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [7:0] b);
    return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle of the PS/2 key decoder.
// master = byte source and event consumer, slave = the decoder itself.
interface ps2_key_decoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             evt_valid;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             evt_repeat;
  logic             key_down;
  logic [7:0]       cur_code;
  logic             cur_ext;
  logic             shift;
  logic [CNT_W-1:0] press_cnt;
  logic [7:0]       ascii;

  modport master (
    output in_valid, in_byte,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
           key_down, cur_code, cur_ext, shift, press_cnt, ascii
  );

  modport slave (
    input  in_valid, in_byte,
    output evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
           key_down, cur_code, cur_ext, shift, press_cnt, ascii
  );
endinterface

// File: rtl/ps2_ascii_lut.sv
// Set-2 scan code to ASCII for letters, digits, space, enter and backspace.
// Shift selects uppercase letters and the shifted digit symbols; extended
// and unmapped codes give 00. Used only when PS2_ASCII_EN is defined.
module ps2_ascii_lut (
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);
  logic [7:0] lower;
  logic [7:0] upper;

  // Pure lookup: both the unshifted and shifted character per code
  always_comb begin
    lower = 8'h00;
    upper = 8'h00;
    case (code_i)
      8'h1C: begin lower = "a"; upper = "A"; end
      8'h32: begin lower = "b"; upper = "B"; end
      8'h21: begin lower = "c"; upper = "C"; end
      8'h23: begin lower = "d"; upper = "D"; end
      8'h24: begin lower = "e"; upper = "E"; end
      8'h2B: begin lower = "f"; upper = "F"; end
      8'h34: begin lower = "g"; upper = "G"; end
      8'h33: begin lower = "h"; upper = "H"; end
      8'h43: begin lower = "i"; upper = "I"; end
      8'h3B: begin lower = "j"; upper = "J"; end
      8'h42: begin lower = "k"; upper = "K"; end
      8'h4B: begin lower = "l"; upper = "L"; end
      8'h3A: begin lower = "m"; upper = "M"; end
      8'h31: begin lower = "n"; upper = "N"; end
      8'h44: begin lower = "o"; upper = "O"; end
      8'h4D: begin lower = "p"; upper = "P"; end
      8'h15: begin lower = "q"; upper = "Q"; end
      8'h2D: begin lower = "r"; upper = "R"; end
      8'h1B: begin lower = "s"; upper = "S"; end
      8'h2C: begin lower = "t"; upper = "T"; end
      8'h3C: begin lower = "u"; upper = "U"; end
      8'h2A: begin lower = "v"; upper = "V"; end
      8'h1D: begin lower = "w"; upper = "W"; end
      8'h22: begin lower = "x"; upper = "X"; end
      8'h35: begin lower = "y"; upper = "Y"; end
      8'h1A: begin lower = "z"; upper = "Z"; end
      8'h16: begin lower = "1"; upper = "!"; end
      8'h1E: begin lower = "2"; upper = "@"; end
      8'h26: begin lower = "3"; upper = "#"; end
      8'h25: begin lower = "4"; upper = "$"; end
      8'h2E: begin lower = "5"; upper = "%"; end
      8'h36: begin lower = "6"; upper = "^"; end
      8'h3D: begin lower = "7"; upper = "&"; end
      8'h3E: begin lower = "8"; upper = "*"; end
      8'h46: begin lower = "9"; upper = "("; end
      8'h45: begin lower = "0"; upper = ")"; end
      8'h29: begin lower = 8'h20; upper = 8'h20; end
      8'h5A: begin lower = 8'h0D; upper = 8'h0D; end
      8'h66: begin lower = 8'h08; upper = 8'h08; end
      default: ;
    endcase
  end

  assign ascii_o = ext_i ? 8'h00 : (shift_i ? upper : lower);
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set-2 key decoder: folds E0/F0/E1 prefixes into single key
// events, tracks the held key, shift state and a non-repeat press counter.
// Optional feature: define PS2_ASCII_EN to build the registered ascii output.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int E1_SKIP = 7
) (
  input logic              clk,
  input logic              clrn,
  ps2_key_decoder_if.slave bus
);
  localparam logic [7:0] SKIP_LOAD = 8'(E1_SKIP);

  logic [2:0]       state_q, state_d;
  logic [7:0]       skip_q, skip_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_brk_q, evt_brk_d;
  logic             evt_rep_q, evt_rep_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic             cur_ext_q, cur_ext_d;
  logic             shift_q, shift_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [7:0]       ascii_q, ascii_d;

  logic fire, fire_ext, fire_brk, match;

  // Prefix FSM: decides whether the incoming byte completes a key event
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    skip_d   = skip_q;
    fire     = 1'b0;
    fire_ext = 1'b0;
    fire_brk = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_byte == PS2_EXT)        state_d = ST_EXT;
          else if (bus.in_byte == PS2_BRK)   state_d = ST_BRK;
          else if (bus.in_byte == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LOAD;
          end else if (!is_ignored(bus.in_byte)) fire = 1'b1;
        end
        ST_EXT: begin
          if (bus.in_byte == PS2_BRK)        state_d = ST_EXT_BRK;
          else if (bus.in_byte == PS2_EXT)   state_d = ST_EXT;
          else if (bus.in_byte == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LOAD;
          end else begin
            fire     = 1'b1;
            fire_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (bus.in_byte == PS2_BRK)      state_d = ST_BRK;
          else if (bus.in_byte == PS2_EXT) state_d = ST_EXT_BRK;
          else begin
            fire     = 1'b1;
            fire_brk = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (bus.in_byte != PS2_BRK && bus.in_byte != PS2_EXT) begin
            fire     = 1'b1;
            fire_ext = 1'b1;
            fire_brk = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_SKIP: begin
          // The byte that brings the count to zero is the last one swallowed
          if (skip_q <= 8'd1) begin
            skip_d  = 8'd0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign match = (bus.in_byte == cur_code_q) && (fire_ext == cur_ext_q);

  // Key tracking: event fields, held key, shift and press counter
  always_comb begin
    evt_valid_d = fire;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    evt_rep_d   = evt_rep_q;
    key_down_d  = key_down_q;
    cur_code_d  = cur_code_q;
    cur_ext_d   = cur_ext_q;
    shift_d     = shift_q;
    press_cnt_d = press_cnt_q;
    if (fire) begin
      evt_code_d = bus.in_byte;
      evt_ext_d  = fire_ext;
      evt_brk_d  = fire_brk;
      evt_rep_d  = 1'b0;
      if (!fire_brk) begin
        if (key_down_q && match) begin
          evt_rep_d = 1'b1;
        end else begin
          press_cnt_d = press_cnt_q + CNT_W'(1);
          cur_code_d  = bus.in_byte;
          cur_ext_d   = fire_ext;
          key_down_d  = 1'b1;
        end
        if (!fire_ext && is_shift(bus.in_byte)) shift_d = 1'b1;
      end else begin
        if (match) key_down_d = 1'b0;
        if (!fire_ext && is_shift(bus.in_byte)) shift_d = 1'b0;
      end
    end
  end

`ifdef PS2_ASCII_EN
  logic [7:0] lut_ascii;

  // Translation uses the shift state in force before this event
  ps2_ascii_lut u_ascii_lut (
    .code_i  (bus.in_byte),
    .ext_i   (fire_ext),
    .shift_i (shift_q),
    .ascii_o (lut_ascii)
  );

  // ascii is captured together with the other event fields
  always_comb begin
    ascii_d = fire ? lut_ascii : ascii_q;
  end
`else
  // No lookup built: ascii register stays at zero
  always_comb begin
    ascii_d = 8'h00;
  end
`endif

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: every register, prefix state included, is reset so clrn discards any partial sequence.
    if (!clrn) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      evt_rep_q   <= 1'b0;
      key_down_q  <= 1'b0;
      cur_code_q  <= '0;
      cur_ext_q   <= 1'b0;
      shift_q     <= 1'b0;
      press_cnt_q <= '0;
      ascii_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      skip_q      <= skip_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      evt_rep_q   <= evt_rep_d;
      key_down_q  <= key_down_d;
      cur_code_q  <= cur_code_d;
      cur_ext_q   <= cur_ext_d;
      shift_q     <= shift_d;
      press_cnt_q <= press_cnt_d;
      ascii_q     <= ascii_d;
    end
  end

  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_code   = evt_code_q;
  assign bus.evt_ext    = evt_ext_q;
  assign bus.evt_break  = evt_brk_q;
  assign bus.evt_repeat = evt_rep_q;
  assign bus.key_down   = key_down_q;
  assign bus.cur_code   = cur_code_q;
  assign bus.cur_ext    = cur_ext_q;
  assign bus.shift      = shift_q;
  assign bus.press_cnt  = press_cnt_q;
  assign bus.ascii      = ascii_q;
endmodule
